// File: rtl/bit_stream_serializer_if.sv
// Parallel-word handshake plus serial bit-stream outputs of the serializer.
interface bit_stream_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             x;
  logic             bit_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output data_in, data_valid,
    input  data_ready, x, bit_valid, frame_start, busy
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, x, bit_valid, frame_start, busy
  );
endinterface

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder with a one-word holding buffer so consecutive words
// stream out without an idle bit between them.
module bit_stream_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  bit_stream_serializer_if.slave bus
);
  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] sh_next;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             hold_full_next;
  logic             accept;
  logic             load_pt;
  logic             go_shift;
  logic             x_q;
  logic             bit_valid_q;
  logic             frame_start_q;
  logic             busy_q;

  assign accept         = bus.data_valid && !hold_full;
  assign load_pt        = (state == IDLE) || (cnt == LAST);
  // The buffer empties at every load point; accept is impossible while it is full.
  assign hold_full_next = load_pt ? 1'b0 : (hold_full | accept);

  always_comb begin
    sh_next  = shreg;
    go_shift = 1'b0;
    if (load_pt) begin
      if (hold_full) begin
        sh_next  = hold;
        go_shift = 1'b1;
      end else if (accept) begin
        sh_next  = bus.data_in;
        go_shift = 1'b1;
      end
    end else begin
      sh_next  = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
      go_shift = 1'b1;
    end
  end

  // Outputs are registered from the next-shifter value so x lines up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      cnt           <= '0;
      x_q           <= IDLE_BIT;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state     <= go_shift ? SHIFT : IDLE;
      shreg     <= sh_next;
      cnt       <= load_pt ? '0 : cnt + CW'(1);
      hold_full <= hold_full_next;
      if (!load_pt && accept) begin
        hold <= bus.data_in;
      end
      x_q           <= go_shift ? (LSB_FIRST ? sh_next[0] : sh_next[WIDTH-1]) : IDLE_BIT;
      bit_valid_q   <= go_shift;
      frame_start_q <= go_shift && load_pt;
      busy_q        <= go_shift | hold_full_next;
    end
  end

  assign bus.data_ready  = !hold_full;
  assign bus.x           = x_q;
  assign bus.bit_valid   = bit_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_bit_stream_serializer.sv
// Two serializer configurations driven by the same stimulus, each compared
// against a queue-of-pending-bits reference model.
module tb_bit_stream_serializer;
  localparam int unsigned W = 8;

  typedef struct packed {
    logic b;
    logic f;
  } ent_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic last_acc;
  logic [23:0] cap0;
  logic [23:0] cap1;
  ent_t q0[$];
  ent_t q1[$];

  bit_stream_serializer_if #(.WIDTH(W)) ifc0 ();
  bit_stream_serializer_if #(.WIDTH(W)) ifc1 ();

  bit_stream_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(ifc0)
  );
  bit_stream_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(ifc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    ifc0.data_valid = v;
    ifc0.data_in    = d;
    ifc1.data_valid = v;
    ifc1.data_in    = d;
  endtask

  // Model: each queue holds the bits still to appear on x, front = bit on x now.
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < int'(W); i++) begin
      q0.push_back(ent_t'{b: w[W-1-i], f: (i == 0)});
      q1.push_back(ent_t'{b: w[i],     f: (i == 0)});
    end
  endtask

  task automatic check_all();
    chk("ready0", {31'b0, ifc0.data_ready},  {31'b0, q0.size() <= W});
    chk("x0",     {31'b0, ifc0.x},           {31'b0, (q0.size() > 0) ? q0[0].b : 1'b0});
    chk("bv0",    {31'b0, ifc0.bit_valid},   {31'b0, q0.size() > 0});
    chk("fs0",    {31'b0, ifc0.frame_start}, {31'b0, (q0.size() > 0) && q0[0].f});
    chk("busy0",  {31'b0, ifc0.busy},        {31'b0, q0.size() > 0});
    chk("ready1", {31'b0, ifc1.data_ready},  {31'b0, q1.size() <= W});
    chk("x1",     {31'b0, ifc1.x},           {31'b0, (q1.size() > 0) ? q1[0].b : 1'b1});
    chk("bv1",    {31'b0, ifc1.bit_valid},   {31'b0, q1.size() > 0});
    chk("fs1",    {31'b0, ifc1.frame_start}, {31'b0, (q1.size() > 0) && q1[0].f});
    chk("busy1",  {31'b0, ifc1.busy},        {31'b0, q1.size() > 0});
  endtask

  task automatic tick();
    @(posedge clk);
    last_acc = rst_n && ifc0.data_valid && (q0.size() <= W);
    if (q0.size() > 0) void'(q0.pop_front());
    if (q1.size() > 0) void'(q1.pop_front());
    if (last_acc) push_word(ifc0.data_in);
    #1;
    cap0 = {cap0[22:0], ifc0.x};
    cap1 = {cap1[22:0], ifc1.x};
    check_all();
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0);
    repeat (n) tick();
  endtask

  // Holds valid with the word until accepted; valid stays high afterwards.
  task automatic send(input logic [W-1:0] w);
    logic done;
    done = 1'b0;
    drive(1'b1, w);
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      if (last_acc) done = 1'b1;
    end
    chk("send_accept", {31'b0, done}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cap0   = '0;
    cap1   = '0;
    rst_n  = 1'b0;
    drive(1'b1, 8'hFF);
    repeat (3) tick();
    #3 rst_n = 1'b1;
    idle(3);

    send(8'hAA);
    idle(7);
    chk("aa_stream", {24'b0, cap0[7:0]}, 32'hAA);
    idle(3);

    send(8'hF0);
    send(8'h0F);
    send(8'h55);
    idle(14);
    chk("b2b_stream", {8'b0, cap0}, 32'hF00F55);
    idle(2);

    send(8'h05);
    idle(7);
    chk("lsb_05", {24'b0, cap1[7:0]}, 32'hA0);
    send(8'h00);
    idle(7);
    chk("idle1_zeros", {24'b0, cap1[7:0]}, 32'h00);
    idle(3);
    chk("idle1_x", {31'b0, ifc1.x}, 32'd1);

    send(8'h3C);
    idle(7);
    send(8'hC3);
    idle(7);
    chk("loadpt_stream", {16'b0, cap0[15:0]}, 32'h3CC3);
    idle(2);

    // Mid-word reset with a second word held.
    send(8'h9A);
    send(8'h65);
    idle(2);
    #2 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1 check_all();
    drive(1'b1, 8'h77);
    repeat (2) tick();
    #3 rst_n = 1'b1;
    idle(4);
    send(8'h96);
    idle(8);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom));
      tick();
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
